// File: rtl/adc_signal_conditioner.sv
// rtl/adc_signal_conditioner.sv - sampled moving-average filter for accel/CDS ADC codes with throttle level and headlight hysteresis
// Optional feature macro: ACCEL_DEADZONE_EN (forces small accelerator averages to zero)
module adc_signal_conditioner #(
  parameter int SAMPLE_DIV    = 50000,
  parameter int AVG_LOG2      = 3,
  parameter int CDS_DARK_TH   = 80,
  parameter int CDS_BRIGHT_TH = 120,
  parameter int HOLD_CNT      = 4,
  parameter int DEADZONE      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc_accel,
  input  logic [7:0] adc_cds,
  output logic [7:0] accel_filt,
  output logic [7:0] cds_filt,
  output logic [3:0] accel_level,
  output logic       headlight_on,
  output logic       sample_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 8 + AVG_LOG2;
  localparam int CW    = $clog2(SAMPLE_DIV);

  localparam logic [CW-1:0]       DIV_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0]       DIV_STEP = CW'(1);
  localparam logic [AVG_LOG2-1:0] PTR_STEP = AVG_LOG2'(1);
  localparam logic [7:0]          DARK_TH  = 8'(CDS_DARK_TH);
  localparam logic [7:0]          BRIGHT_TH = 8'(CDS_BRIGHT_TH);
  localparam logic [3:0]          HOLD_TGT = 4'(HOLD_CNT);
  localparam logic [3:0]          HOLD_STEP = 4'd1;
  localparam logic [7:0]          DZ_TH    = 8'(DEADZONE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  typedef enum logic {
    DAY   = 1'b0,
    NIGHT = 1'b1
  } light_t;

  state_t state, state_next;
  light_t light;

  logic [CW-1:0]       div_cnt;
  logic                tick;
  logic [7:0]          cap_accel, cap_cds;
  logic [7:0]          hist_accel [DEPTH];
  logic [7:0]          hist_cds   [DEPTH];
  logic [SW-1:0]       sum_accel, sum_cds;
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [3:0]          hold;

  logic [7:0] accel_avg, cds_avg, accel_out;
  logic [3:0] level_new;
  logic       qualify;
  logic [3:0] hold_inc;
  logic       toggle;

  assign tick = (div_cnt == DIV_LAST);

  // Free-running sample-rate divider, wraps after SAMPLE_DIV clocks
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_STEP;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: capture on tick, accumulate, then publish
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (tick) state_next = S_ACCUM;
      S_ACCUM:  state_next = S_OUTPUT;
      S_OUTPUT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Averages and derived values computed from the freshly updated sums
  always_comb begin
    accel_avg = 8'(sum_accel >> AVG_LOG2);
    cds_avg   = 8'(sum_cds >> AVG_LOG2);
    accel_out = accel_avg;
`ifdef ACCEL_DEADZONE_EN
    if (accel_avg < DZ_TH) begin
      accel_out = 8'd0;
    end
`endif
    // 255*10 fits in 12 bits; the top nibble is the 0..9 level
    level_new = 4'(({4'd0, accel_out} * 12'd10) >> 8);
    qualify   = (light == DAY) ? (cds_avg < DARK_TH) : (cds_avg > BRIGHT_TH);
    hold_inc  = qualify ? (hold + HOLD_STEP) : 4'd0;
    toggle    = (hold_inc == HOLD_TGT);
  end

`ifndef ACCEL_DEADZONE_EN
  // Dead-zone threshold has no effect in this build
  logic unused_deadzone;
  assign unused_deadzone = ^DZ_TH;
`endif

  // Datapath: capture, sliding-window sum update, output publish and headlight hysteresis
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_accel    <= '0;
      cap_cds      <= '0;
      sum_accel    <= '0;
      sum_cds      <= '0;
      wr_ptr       <= '0;
      hold         <= '0;
      light        <= DAY;
      accel_filt   <= '0;
      cds_filt     <= '0;
      accel_level  <= '0;
      headlight_on <= 1'b0;
      sample_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_accel[i] <= '0;
        hist_cds[i]   <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            cap_accel <= adc_accel;
            cap_cds   <= adc_cds;
          end
        end
        S_ACCUM: begin
          // Oldest entry is always part of the sum, so the subtraction cannot underflow
          sum_accel          <= sum_accel + SW'(cap_accel) - SW'(hist_accel[wr_ptr]);
          sum_cds            <= sum_cds + SW'(cap_cds) - SW'(hist_cds[wr_ptr]);
          hist_accel[wr_ptr] <= cap_accel;
          hist_cds[wr_ptr]   <= cap_cds;
          wr_ptr             <= wr_ptr + PTR_STEP;
        end
        S_OUTPUT: begin
          accel_filt   <= accel_out;
          cds_filt     <= cds_avg;
          accel_level  <= level_new;
          sample_valid <= 1'b1;
          if (toggle) begin
            hold         <= 4'd0;
            light        <= (light == DAY) ? NIGHT : DAY;
            headlight_on <= (light == DAY);
          end else begin
            hold <= hold_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_signal_conditioner.sv
// tb/tb_adc_signal_conditioner.sv - scoreboard bench for adc_signal_conditioner with a sliding-window reference model
module tb_adc_signal_conditioner;

  localparam int SAMPLE_DIV = 8;
  localparam int WIN        = 8;
  localparam int DARK       = 80;
  localparam int BRIGHT     = 120;
  localparam int HOLD       = 4;
  localparam int DZ         = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] adc_accel = 8'd0;
  logic [7:0] adc_cds = 8'd0;
  logic [7:0] accel_filt, cds_filt;
  logic [3:0] accel_level;
  logic       headlight_on, sample_valid;

  adc_signal_conditioner #(
    .SAMPLE_DIV(SAMPLE_DIV), .AVG_LOG2(3), .CDS_DARK_TH(DARK),
    .CDS_BRIGHT_TH(BRIGHT), .HOLD_CNT(HOLD), .DEADZONE(DZ)
  ) dut (
    .clk(clk), .rst(rst), .adc_accel(adc_accel), .adc_cds(adc_cds),
    .accel_filt(accel_filt), .cds_filt(cds_filt), .accel_level(accel_level),
    .headlight_on(headlight_on), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int af;
    int cf;
    int lvl;
    int hl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   expect_cyc = 0;

  int hist_a[$];
  int hist_c[$];
  bit night;
  int run;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    hist_a.delete();
    hist_c.delete();
    for (int i = 0; i < WIN; i++) begin
      hist_a.push_back(0);
      hist_c.push_back(0);
    end
    night = 1'b0;
    run = 0;
  endfunction

  // Mean of the last WIN samples, throttle tenths of full scale, dark/bright streak counting
  function automatic exp_t model_step(int a, int c);
    exp_t e;
    int sa, sc;
    bit qual;
    hist_a.push_back(a);
    void'(hist_a.pop_front());
    hist_c.push_back(c);
    void'(hist_c.pop_front());
    sa = 0;
    sc = 0;
    foreach (hist_a[i]) sa += hist_a[i];
    foreach (hist_c[i]) sc += hist_c[i];
    e.af = sa / WIN;
    e.cf = sc / WIN;
`ifdef ACCEL_DEADZONE_EN
    if (e.af < DZ) e.af = 0;
`endif
    e.lvl = (e.af * 10) / 256;
    qual = night ? (e.cf > BRIGHT) : (e.cf < DARK);
    run = qual ? run + 1 : 0;
    if (run == HOLD) begin
      night = !night;
      run = 0;
    end
    e.hl = night ? 1 : 0;
    return e;
  endfunction

  // Monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && sample_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(accel_filt) != e.af) begin
          errors++;
          $display("FAIL accel_filt got %0d want %0d", accel_filt, e.af);
        end
        checks++;
        if (int'(cds_filt) != e.cf) begin
          errors++;
          $display("FAIL cds_filt got %0d want %0d", cds_filt, e.cf);
        end
        checks++;
        if (int'(accel_level) != e.lvl) begin
          errors++;
          $display("FAIL accel_level got %0d want %0d", accel_level, e.lvl);
        end
        checks++;
        if (int'(headlight_on) != e.hl) begin
          errors++;
          $display("FAIL headlight_on got %0d want %0d", headlight_on, e.hl);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({accel_filt, cds_filt, accel_level, headlight_on, sample_valid} != '0) begin
      errors++;
      $display("FAIL %s outputs af=%0d cf=%0d lvl=%0d hl=%0d sv=%0d want all 0",
               name, accel_filt, cds_filt, accel_level, headlight_on, sample_valid);
    end
  endtask

  task automatic release_reset();
    rst = 1'b1;
    expect_cyc = cyc + SAMPLE_DIV + 2;
    model_reset();
  endtask

  // Issue one sample: junk first (must be ignored), real value before the tick, then wait for the pulse
  task automatic send(input int a, input int c);
    bit got;
    exp_q.push_back(model_step(a, c));
    adc_accel = 8'($urandom);
    adc_cds   = 8'($urandom);
    @(negedge clk);
    adc_accel = 8'(a);
    adc_cds   = 8'(c);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL pulse_timeout no sample_valid within 40 cycles");
    end else if (cyc != expect_cyc) begin
      errors++;
      $display("FAIL pulse_time got cycle %0d want %0d", cyc, expect_cyc);
    end
    expect_cyc = cyc + SAMPLE_DIV;
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset");
    end
    release_reset();

    // Warm-up ramp of a held accelerator and bright CDS
    for (int i = 0; i < 10; i++) send(200, 255);
    // Dark transition
    for (int i = 0; i < 10; i++) send(200, 0);
    // Bright transition
    for (int i = 0; i < 10; i++) send(200, 255);
    // Between thresholds: must not toggle
    for (int i = 0; i < 12; i++) send(50, (i % 2 == 0) ? 70 : 100);
    // Small accelerator value, dead-zone boundary
    for (int i = 0; i < 10; i++) send(30, 100);
    // Randomised traffic with both dark and bright bursts
    for (int i = 0; i < 40; i++) begin
      int c;
      case ($urandom_range(0, 2))
        0: c = $urandom_range(60, 140);
        1: c = $urandom_range(0, 40);
        default: c = $urandom_range(200, 255);
      endcase
      send($urandom_range(0, 255), c);
    end
    // Get into NIGHT, then reset while the FSM is accumulating
    for (int i = 0; i < 10; i++) send($urandom_range(0, 255), 0);
    adc_accel = 8'($urandom);
    adc_cds   = 8'($urandom);
    repeat (SAMPLE_DIV - 2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_before_mid_reset got %0d want 0", exp_q.size());
    end
    release_reset();
    for (int i = 0; i < 10; i++) send($urandom_range(0, 255), $urandom_range(0, 255));

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_signal_conditioner.md
Name: adc_signal_conditioner

Overview:
- Sits directly downstream of the SPI ADC controller and consumes its two free-running 8-bit results (accelerator pedal, CDS light sensor).
- Samples both channels at a fixed rate and smooths each with a power-of-two moving average.
- Produces a filtered accelerator value with a 0..9 throttle level, and a debounced headlight on/off decision with hysteresis, for the vehicle core and display logic.

Parameters:
- SAMPLE_DIV, 50000: clocks between sample ticks (1 kHz at 50 MHz); legal range 4 or more.
- AVG_LOG2, 3: log2 of averaging window (8 samples); legal range 1..4.
- CDS_DARK_TH, 80: filtered CDS strictly below this value counts as dark.
- CDS_BRIGHT_TH, 120: filtered CDS strictly above this value counts as bright; must be greater than CDS_DARK_TH.
- HOLD_CNT, 4: consecutive qualifying samples required to change headlight state; legal range 1..15.
- DEADZONE, 32: accelerator dead-zone threshold (optional feature only).

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- adc_accel  in  8  latest accelerator ADC code
- adc_cds  in  8  latest CDS ADC code; low = dark
- accel_filt  out  8  moving-average accelerator value
- cds_filt  out  8  moving-average CDS value
- accel_level  out  4  throttle level 0..9
- headlight_on  out  1  1 = headlights requested
- sample_valid  out  1  one-cycle pulse when all outputs update

Behaviour:
- Reset (rst=0 at a rising clk edge):
  - All outputs go to 0.
  - Divider counter, both history buffers, running sums, hold counter and write pointer clear to 0.
  - FSM goes to S_IDLE; light state goes to DAY.
  - Reset asserted in any state aborts the cycle in progress with no output update.
- Divider: counter runs 0..SAMPLE_DIV-1, then wraps. The tick fires when the counter equals SAMPLE_DIV-1, so the first tick occurs SAMPLE_DIV cycles after reset release.
- FSM:
  - S_IDLE: wait for tick; on tick, register adc_accel and adc_cds into the capture registers, then go to S_ACCUM.
  - S_ACCUM: per channel, sum <= sum + new - buf[wr_ptr]; buf[wr_ptr] <= new; wr_ptr increments modulo 2^AVG_LOG2; go to S_OUTPUT.
  - S_OUTPUT:
    - Compute filt = sum >> AVG_LOG2 (truncating).
    - Compute accel_level = (accel_filt_new * 10) >> 8, a 12-bit product yielding a 0..9 result.
    - Update the headlight logic.
    - Pulse sample_valid for exactly one cycle; return to S_IDLE.
- Latency: sample_valid and all new outputs appear 2 cycles after the tick edge. Outputs hold their values between pulses.
- Widths:
  - Sums are 8+AVG_LOG2 bits; maximum 255 x 2^AVG_LOG2, so no overflow.
  - The subtract-before-add result never goes negative, because buf[wr_ptr] is always included in sum.
- Warm-up: buffers start at 0, so filtered values ramp over the first 2^AVG_LOG2 samples. There is no special startup handling.
- Headlight (evaluated in S_OUTPUT on the new cds_filt):
  - DAY state:
    - If cds_filt < CDS_DARK_TH, increment the hold counter; otherwise clear it.
    - When the counter reaches HOLD_CNT, go to NIGHT, set headlight_on=1 and clear the counter.
  - NIGHT state:
    - If cds_filt > CDS_BRIGHT_TH, increment the hold counter; otherwise clear it.
    - When the counter reaches HOLD_CNT, go to DAY, set headlight_on=0 and clear the counter.
  - Values between the two thresholds clear the counter and hold the current state.
  - headlight_on changes in the same cycle as the sample_valid pulse.
- Inputs are only sampled on a tick. Input changes between ticks are ignored, because ADC outputs are held registers.

Optional Feature:
- Macro: ACCEL_DEADZONE_EN
- Defined: if the computed accelerator average < DEADZONE, then accel_filt=0 and accel_level=0. Otherwise the outputs are unchanged. The running sum and buffer always hold raw values.
- Undefined: no dead-zone; the DEADZONE parameter is ignored.

Test Plan:
- Reset and first tick (SAMPLE_DIV=8): all outputs 0 during reset → first sample_valid 10 cycles after rst goes high, with outputs still 0 when both inputs are 0.
- Accelerator ramp: adc_accel=200 held → accel_filt sequence 25,50,75,100,125,150,175,200, then steady 200 → accel_level steady at 7.
- Night transition: CDS steady at 255 (cds_filt=255), then adc_cds=0 → cds_filt 223,191,159,127,95,63,31,0,0 → headlight_on rises on the 9th post-drop pulse, not earlier.
- Day transition: from the night steady state, adc_cds=255 → cds_filt 31,63,95,127,159,191,223 → headlight_on falls on the 7th pulse. Also: a sequence alternating 70 and 100 after warm-up → headlight never toggles.
- Dead-zone: adc_accel=30 held for 8+ samples → without the macro, accel_filt=30 and accel_level=1; with ACCEL_DEADZONE_EN, accel_filt=0 and accel_level=0.
- Reset mid-operation: drive rst=0 on the cycle in S_ACCUM → no sample_valid pulse; outputs, buffers and light state cleared; next pulse SAMPLE_DIV+2 cycles after release.
